// File: rtl/turbo_encoder_core.sv
// turbo_encoder_core: two 8-state RSC constituent encoders (g0=1+D^2+D^3,
// g1=1+D+D^3), one on natural-order bits and one on interleaved bits, with a
// programmable block length, valid/ready input and two 3-cycle tail phases.
// Optional build macro: TRELLIS_DBG_EN adds the dbg_state observation port.
module turbo_encoder_core #(
  parameter int KMAX = 6144,
  parameter int KMIN = 40,
  parameter int KW   = $clog2(KMAX+1)
) (
  input  logic          clk,
  input  logic          aclr,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          ck,
  input  logic          ck_int,
  output logic          out_valid,
  output logic          xk,
  output logic          zk,
  output logic          zk_int,
  output logic          tailbits,
  output logic          busy,
  output logic          done,
  output logic          err
`ifdef TRELLIS_DBG_EN
  ,
  output logic [5:0]    dbg_state
`endif
);

  typedef enum logic [1:0] {IDLE, DATA, TAIL1, TAIL2} state_t;

  state_t        state, state_nxt;
  logic [KW-1:0] k_q, cnt;
  logic [1:0]    tcnt;
  // Encoder state vectors are {s2,s1,s0}, s0 newest.
  logic [2:0]    e1, e2;

  logic k_ok, start_ok, acc, last_bit, last_tail;
  logic fb1, fb2, nw1, nw2, pz1, pz2, tz1, tz2;

  assign k_ok      = (k_len >= KW'(KMIN)) && (k_len <= KW'(KMAX));
  assign start_ok  = start && (state == IDLE) && k_ok;
  assign in_ready  = (state == DATA);
  assign acc       = in_ready && in_valid;
  assign last_bit  = acc && (cnt == k_q - KW'(1));
  assign last_tail = (tcnt == 2'd2);

  // Trellis step: data parity uses the new bit; tail parity forces s=0.
  assign fb1 = e1[1] ^ e1[2];
  assign fb2 = e2[1] ^ e2[2];
  assign nw1 = fb1 ^ ck;
  assign nw2 = fb2 ^ ck_int;
  assign pz1 = nw1 ^ e1[0] ^ e1[2];
  assign pz2 = nw2 ^ e2[0] ^ e2[2];
  assign tz1 = e1[0] ^ e1[2];
  assign tz2 = e2[0] ^ e2[2];

`ifdef TRELLIS_DBG_EN
  assign dbg_state = {e2, e1};
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next-state: block sequencing IDLE->DATA->TAIL1->TAIL2->IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok)  state_nxt = DATA;
      DATA:    if (last_bit)  state_nxt = TAIL1;
      TAIL1:   if (last_tail) state_nxt = TAIL2;
      TAIL2:   if (last_tail) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Encoder states, bit counter, tail step counter and latched block length.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      k_q  <= '0;
      cnt  <= '0;
      tcnt <= '0;
      e1   <= '0;
      e2   <= '0;
    end else if (start_ok) begin
      k_q  <= k_len;
      cnt  <= '0;
      tcnt <= '0;
      e1   <= '0;
      e2   <= '0;
    end else begin
      case (state)
        DATA: if (acc) begin
          e1  <= {e1[1:0], nw1};
          e2  <= {e2[1:0], nw2};
          cnt <= cnt + KW'(1);
        end
        TAIL1: begin
          e1   <= {e1[1:0], 1'b0};
          tcnt <= last_tail ? 2'd0 : tcnt + 2'd1;
        end
        TAIL2: begin
          e2   <= {e2[1:0], 1'b0};
          tcnt <= last_tail ? 2'd0 : tcnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Registered outputs, one cycle after each accepted bit or tail step.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      out_valid <= 1'b0;
      xk        <= 1'b0;
      zk        <= 1'b0;
      zk_int    <= 1'b0;
      tailbits  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      xk        <= 1'b0;
      zk        <= 1'b0;
      zk_int    <= 1'b0;
      tailbits  <= 1'b0;
      done      <= 1'b0;
      err       <= start && ((state != IDLE) || !k_ok);
      busy      <= (busy && !done) || start_ok;
      case (state)
        DATA: if (acc) begin
          out_valid <= 1'b1;
          xk        <= ck;
          zk        <= pz1;
          zk_int    <= pz2;
        end
        TAIL1: begin
          out_valid <= 1'b1;
          tailbits  <= 1'b1;
          xk        <= fb1;
          zk        <= tz1;
        end
        TAIL2: begin
          out_valid <= 1'b1;
          tailbits  <= 1'b1;
          xk        <= fb2;
          zk_int    <= tz2;
          done      <= last_tail;
        end
        default: ;
      endcase
    end
  end

endmodule
